// File: rtl/z_buffer_mem_if.sv
// Depth-buffer memory handshake bundle between the depth-test initiator
// (master) and the depth-buffer responder (slave).
interface z_buffer_mem_if #(
    parameter int Z_SIZE    = 8,
    parameter int ADDR_SIZE = 32
);
    logic                 buf_r_w;
    logic [ADDR_SIZE-1:0] buf_addr;
    logic [Z_SIZE-1:0]    buf_data_w;
    logic [Z_SIZE-1:0]    buf_data_r;
    logic                 data_r_ready;
    logic                 data_r_valid;
    logic                 data_w_valid;
    logic                 data_w_ready;

    modport master (
        output buf_r_w, buf_addr, buf_data_w, data_r_ready, data_w_valid,
        input  buf_data_r, data_r_valid, data_w_ready
    );

    modport slave (
        input  buf_r_w, buf_addr, buf_data_w, data_r_ready, data_w_valid,
        output buf_data_r, data_r_valid, data_w_ready
    );
endinterface

// File: rtl/z_buffer_mem.sv
// z_buffer_mem: responder side of the depth-buffer memory. Holds
// X_RES*Y_RES depth entries, serves reads (1-cycle latency, held until
// handshake) and writes (acked combinationally in IDLE), provides a
// fast-clear to all-ones and a sticky out-of-range address error.
// Optional: define Z_BUFFER_MEM_STATS_EN to add read/write counters.
module z_buffer_mem #(
    parameter int Z_SIZE    = 8,
    parameter int X_RES     = 4,
    parameter int Y_RES     = 4,
    parameter int DEPTH     = X_RES * Y_RES,
    parameter int IDX_SIZE  = $clog2(DEPTH),
    parameter int ADDR_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [ADDR_SIZE-1:0] buffer_base_address_i,
    input  logic                 clear_i,
    output logic                 busy_o,
    output logic                 addr_err_o,
`ifdef Z_BUFFER_MEM_STATS_EN
    output logic [31:0]          rd_count_o,
    output logic [31:0]          wr_count_o,
`endif
    z_buffer_mem_if.slave        bus
);

    typedef enum logic [1:0] {IDLE, RD_RESP, CLEAR} state_t;

    localparam logic [ADDR_SIZE-1:0] DEPTH_A  = ADDR_SIZE'(DEPTH);
    localparam logic [IDX_SIZE-1:0]  LAST_IDX = IDX_SIZE'(DEPTH - 1);

    state_t                state;
    logic [Z_SIZE-1:0]     mem [DEPTH];
    logic [IDX_SIZE-1:0]   clr_cnt;
    logic [ADDR_SIZE-1:0]  off;
    logic                  in_range;
    logic [IDX_SIZE-1:0]   idx;
    logic                  wr_req;
    logic                  rd_req;
    logic                  mem_we;
    logic [IDX_SIZE-1:0]   mem_waddr;
    logic [Z_SIZE-1:0]     mem_wdata;

    // Address decode: offset from the buffer base and range check.
    always_comb begin
        off      = bus.buf_addr - buffer_base_address_i;
        in_range = (bus.buf_addr >= buffer_base_address_i) && (off < DEPTH_A);
        idx      = off[IDX_SIZE-1:0];
    end

    // Request qualification: clear beats write beats read, only in IDLE.
    assign wr_req = (state == IDLE) && !clear_i && bus.data_w_valid && !bus.buf_r_w;
    assign rd_req = (state == IDLE) && !clear_i && bus.data_r_ready && bus.buf_r_w;
    assign bus.data_w_ready = rst_ni && wr_req;

    // Single array write port shared by the fast-clear sweep and host writes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = bus.buf_data_w;
        if (rst_ni && state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = '1;
        end else if (bus.data_w_ready && in_range) begin
            mem_we = 1'b1;
        end
    end

    // Array storage write.
    always_ff @(posedge clk_i) begin
        // NOTE: the array carries no reset so it can map onto block RAM.
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM with registered read response, busy and error flags.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_ni) begin
            state            <= IDLE;
            bus.data_r_valid <= 1'b0;
            bus.buf_data_r   <= '0;
            busy_o           <= 1'b0;
            addr_err_o       <= 1'b0;
            clr_cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_i) begin
                        state      <= CLEAR;
                        busy_o     <= 1'b1;
                        clr_cnt    <= '0;
                        addr_err_o <= 1'b0;
                    end else if (wr_req) begin
                        if (!in_range) addr_err_o <= 1'b1;
                    end else if (rd_req) begin
                        state            <= RD_RESP;
                        bus.data_r_valid <= 1'b1;
                        bus.buf_data_r   <= in_range ? mem[idx] : '1;
                        if (!in_range) addr_err_o <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (bus.data_r_ready) begin
                        state            <= IDLE;
                        bus.data_r_valid <= 1'b0;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_IDX) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef Z_BUFFER_MEM_STATS_EN
    // Transaction counters: read handshakes and accepted (incl. dropped) writes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_count_o <= '0;
            wr_count_o <= '0;
        end else begin
            if (state == RD_RESP && bus.data_r_valid && bus.data_r_ready) begin
                rd_count_o <= rd_count_o + 32'd1;
            end
            if (bus.data_w_ready) begin
                wr_count_o <= wr_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_z_buffer_mem.sv
// Testbench for z_buffer_mem: directed vectors with a read-data scoreboard.
// Expected read data is queued at request time and popped by an
// independent monitor on each read handshake.
module tb_z_buffer_mem;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] buffer_base_address_i;
    logic        clear_i;
    logic        busy_o;
    logic        addr_err_o;
`ifdef Z_BUFFER_MEM_STATS_EN
    logic [31:0] rd_count_o;
    logic [31:0] wr_count_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    z_buffer_mem_if #(.Z_SIZE(8), .ADDR_SIZE(32)) bus ();

    z_buffer_mem dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .buffer_base_address_i (buffer_base_address_i),
        .clear_i               (clear_i),
        .busy_o                (busy_o),
        .addr_err_o            (addr_err_o),
`ifdef Z_BUFFER_MEM_STATS_EN
        .rd_count_o            (rd_count_o),
        .wr_count_o            (wr_count_o),
`endif
        .bus                   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every read handshake pops and compares one expected value.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && bus.data_r_valid && bus.data_r_ready) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 32'(bus.buf_data_r), 32'hDEAD);
                end else begin
                    check("rd_data", 32'(bus.buf_data_r), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] d, input logic exp_ready);
        bus.buf_r_w      = 1'b0;
        bus.buf_addr     = a;
        bus.buf_data_w   = d;
        bus.data_w_valid = 1'b1;
        #2 check("w_ready", 32'(bus.data_w_ready), 32'(exp_ready));
        tick();
        bus.data_w_valid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] exp);
        exp_q.push_back(exp);
        bus.buf_r_w      = 1'b1;
        bus.buf_addr     = a;
        bus.data_r_ready = 1'b1;
        #2 check("rd_valid_req_cycle", 32'(bus.data_r_valid), 32'd0);
        tick();
        #2 check("rd_valid_latency1", 32'(bus.data_r_valid), 32'd1);
        tick();
        bus.data_r_ready = 1'b0;
        #2 check("rd_valid_after_hs", 32'(bus.data_r_valid), 32'd0);
        tick();
    endtask

    task automatic wait_clear_done();
        int n = 0;
        while (busy_o && n < 40) begin
            tick();
            n++;
        end
        check("clear_done", 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst_ni                = 1'b0;
        buffer_base_address_i = 32'h100;
        clear_i               = 1'b0;
        bus.buf_r_w           = 1'b0;
        bus.buf_addr          = '0;
        bus.buf_data_w        = '0;
        bus.data_r_ready      = 1'b0;
        bus.data_w_valid      = 1'b1;
        tick(); tick(); tick();

        // Reset state.
        check("rst_w_ready", 32'(bus.data_w_ready), 32'd0);
        check("rst_r_valid", 32'(bus.data_r_valid), 32'd0);
        check("rst_data_r", 32'(bus.buf_data_r), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(addr_err_o), 32'd0);
        bus.data_w_valid = 1'b0;
        rst_ni = 1'b1;
        tick();

        // Write then read back.
        do_write(32'h105, 8'h3C, 1'b1);
        do_read(32'h105, 8'h3C);
        // Back-to-back write then read of the same address.
        do_write(32'h101, 8'h5A, 1'b1);
        do_read(32'h101, 8'h5A);

        // Fast clear: busy for 16 cycles, writes refused.
        clear_i = 1'b1;
        bus.buf_r_w = 1'b0; bus.buf_addr = 32'h103; bus.buf_data_w = 8'h11;
        bus.data_w_valid = 1'b1;
        #2 check("w_ready_on_clear", 32'(bus.data_w_ready), 32'd0);
        tick();
        clear_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #2 check("busy_during_clear", 32'(busy_o), 32'd1);
            check("w_ready_in_clear", 32'(bus.data_w_ready), 32'd0);
            tick();
        end
        bus.data_w_valid = 1'b0;
        #2 check("busy_after_16", 32'(busy_o), 32'd0);
        tick();
        do_read(32'h100, 8'hFF);
        do_read(32'h10F, 8'hFF);
        do_read(32'h105, 8'hFF);
        do_read(32'h103, 8'hFF);

        // Out-of-range read and write; clear resets the error flag.
        check("err_before", 32'(addr_err_o), 32'd0);
        do_read(32'h110, 8'hFF);
        check("err_after_oor_rd", 32'(addr_err_o), 32'd1);
        do_write(32'h0FF, 8'h77, 1'b1);
        do_read(32'h10F, 8'hFF);
        check("err_held", 32'(addr_err_o), 32'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        #2 check("err_cleared", 32'(addr_err_o), 32'd0);
        wait_clear_done();

        // Read with back-pressure: response held until handshake.
        do_write(32'h102, 8'hC3, 1'b1);
        exp_q.push_back(8'hC3);
        bus.buf_r_w = 1'b1; bus.buf_addr = 32'h102; bus.data_r_ready = 1'b1;
        tick();
        bus.data_r_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2 check("stall_valid", 32'(bus.data_r_valid), 32'd1);
            check("stall_data", 32'(bus.buf_data_r), 32'hC3);
            tick();
        end
        bus.data_r_ready = 1'b1;
        #2 check("stall_hs_valid", 32'(bus.data_r_valid), 32'd1);
        tick();
        bus.data_r_ready = 1'b0;
        #2 check("stall_after_hs", 32'(bus.data_r_valid), 32'd0);
        tick();
        do_write(32'h106, 8'h42, 1'b1);

        // Reset during clear aborts to IDLE.
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        #2 check("busy_cycle7", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        #2 check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_r_valid", 32'(bus.data_r_valid), 32'd0);
        tick();
        do_write(32'h104, 8'hA5, 1'b1);
        do_read(32'h104, 8'hA5);

`ifdef Z_BUFFER_MEM_STATS_EN
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        #2 check("stats_rst_wr", wr_count_o, 32'd0);
        check("stats_rst_rd", rd_count_o, 32'd0);
        tick();
        do_write(32'h100, 8'h01, 1'b1);
        do_write(32'h101, 8'h02, 1'b1);
        do_write(32'h200, 8'h03, 1'b1);
        do_read(32'h100, 8'h01);
        do_read(32'h101, 8'h02);
        check("stats_wr", wr_count_o, 32'd3);
        check("stats_rd", rd_count_o, 32'd2);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        #2 check("stats_wr_rst", wr_count_o, 32'd0);
        check("stats_rd_rst", rd_count_o, 32'd0);
        tick();
`endif

        tick(); tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
